// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the skid-buffered pipeline stage.
package pipe_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_FULL  = ST_FULL
  } stage_st_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat bundle between pipeline stages.
interface pipe_stage_skid_if #(
  parameter int PC_W   = 32,
  parameter int A3_W   = 5,
  parameter int DATA_W = 96
);

  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [A3_W-1:0]   a3;
  logic [DATA_W-1:0] data;

  modport master (
    output valid, pc, a3, data,
    input  ready
  );

  modport slave (
    input  valid, pc, a3, data,
    output ready
  );

endinterface

// File: rtl/pipe_entry.sv
// One beat register {valid, pc, a3, data} with load, clear and drop controls.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int              PC_W   = 32,
  parameter int              A3_W   = 5,
  parameter int              DATA_W = 96,
  parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RESET)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              drop,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [A3_W-1:0]   d_a3,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [A3_W-1:0]   a3,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      valid <= 1'b0;
      pc    <= PC_RST;
      a3    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      a3    <= d_a3;
      data  <= d_data;
    end else if (drop) begin
      // Emptied entry writes $0; pc/data keep last value
      valid <= 1'b0;
      a3    <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with one-entry skid buffer and flush.
// Optional perf counters when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              DATA_W = 96,
  parameter int              PC_W   = 32,
  parameter int              A3_W   = 5,
  parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RESET)
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  pipe_stage_skid_if.slave  in_if,
  pipe_stage_skid_if.master out_if
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  stage_st_t state, state_n;

  logic              m_valid, s_valid;
  logic [PC_W-1:0]   m_pc, s_pc;
  logic [A3_W-1:0]   m_a3, s_a3;
  logic [DATA_W-1:0] m_data, s_data;

  logic              m_load, m_drop, m_sel_skid;
  logic              s_load, s_drop;
  logic [PC_W-1:0]   m_d_pc;
  logic [A3_W-1:0]   m_d_a3;
  logic [DATA_W-1:0] m_d_data;

  logic in_ready, accept, consume;

  // s_valid is a flop, so in_ready has no path from out_ready
  assign in_ready = ~s_valid;
  assign accept   = in_if.valid & in_ready;
  assign consume  = m_valid & out_if.ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    m_load     = 1'b0;
    m_drop     = 1'b0;
    m_sel_skid = 1'b0;
    s_load     = 1'b0;
    s_drop     = 1'b0;
    unique case (1'b1)
      (state == S_EMPTY): begin
        if (accept) begin
          m_load  = 1'b1;
          state_n = S_ONE;
        end
      end
      (state == S_ONE): begin
        if (accept && consume) begin
          m_load = 1'b1;
        end else if (accept) begin
          s_load  = 1'b1;
          state_n = S_FULL;
        end else if (consume) begin
          m_drop  = 1'b1;
          state_n = S_EMPTY;
        end
      end
      (state == S_FULL): begin
        if (consume) begin
          m_load     = 1'b1;
          m_sel_skid = 1'b1;
          s_drop     = 1'b1;
          state_n    = S_ONE;
        end
      end
      default: state_n = S_EMPTY;
    endcase
    if (flush) state_n = S_EMPTY;
  end

  always_comb begin
    m_d_pc   = in_if.pc;
    m_d_a3   = in_if.a3;
    m_d_data = in_if.data;
    if (m_sel_skid) begin
      m_d_pc   = s_pc;
      m_d_a3   = s_a3;
      m_d_data = s_data;
    end
  end

  pipe_entry #(
    .PC_W   (PC_W),
    .A3_W   (A3_W),
    .DATA_W (DATA_W),
    .PC_RST (PC_RST)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .clr    (flush),
    .load   (m_load),
    .drop   (m_drop),
    .d_pc   (m_d_pc),
    .d_a3   (m_d_a3),
    .d_data (m_d_data),
    .valid  (m_valid),
    .pc     (m_pc),
    .a3     (m_a3),
    .data   (m_data)
  );

  pipe_entry #(
    .PC_W   (PC_W),
    .A3_W   (A3_W),
    .DATA_W (DATA_W),
    .PC_RST (PC_RST)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .clr    (flush),
    .load   (s_load),
    .drop   (s_drop),
    .d_pc   (in_if.pc),
    .d_a3   (in_if.a3),
    .d_data (in_if.data),
    .valid  (s_valid),
    .pc     (s_pc),
    .a3     (s_a3),
    .data   (s_data)
  );

  assign in_if.ready = in_ready;
  assign out_if.valid = m_valid;
  assign out_if.pc    = m_pc;
  assign out_if.a3    = m_a3;
  assign out_if.data  = m_data;

`ifdef PIPE_STAGE_PERF_EN
  // Flush leaves the counters alone; only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (m_valid && !out_if.ready)
        stall_cnt <= stall_cnt + 32'd1;
      if (!m_valid)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed beats, queued expectations.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int PC_W   = 32;
  localparam int A3_W   = 5;
  localparam int DATA_W = 96;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [A3_W-1:0]   a3;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   total = 0;
  int   bad   = 0;
  beat_t exp_q[$];

  pipe_stage_skid_if #(.PC_W(PC_W), .A3_W(A3_W), .DATA_W(DATA_W)) up ();
  pipe_stage_skid_if #(.PC_W(PC_W), .A3_W(A3_W), .DATA_W(DATA_W)) dn ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  pipe_stage_skid #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .A3_W   (A3_W),
    .PC_RST (32'h0000_3000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_if      (up),
    .out_if     (dn)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] pc, logic [4:0] a3,
                       logic [95:0] d);
    up.valid = v;
    up.pc    = pc;
    up.a3    = a3;
    up.data  = d;
  endtask

  task automatic expect_beat(logic [31:0] pc, logic [4:0] a3,
                             logic [95:0] d);
    beat_t b;
    b.pc = pc;
    b.a3 = a3;
    b.data = d;
    exp_q.push_back(b);
  endtask

  // Monitor: every transfer downstream must match the queue head
  always @(negedge clk) begin
    if (!reset && !flush && dn.valid && dn.ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {96'd0, dn.pc}, 128'hDEAD);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_pc", 128'(dn.pc), 128'(e.pc));
        chk("out_a3", 128'(dn.a3), 128'(e.a3));
        chk("out_data", 128'(dn.data), 128'(e.data));
      end
    end
  end

  localparam logic [95:0] D0 = 96'h0123_4567_89ab_cdef_0000_0001;
  localparam logic [95:0] D1 = 96'hfeed_beef_cafe_f00d_0000_0002;
  localparam logic [95:0] D2 = 96'h5555_aaaa_3333_cccc_0000_0003;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    dn.ready = 1'b0;
    drive(1'b1, 32'h0000_1234, 5'd7, D0);

    // 1: reset while in_valid is high
    tick();
    chk("rst_out_valid", 128'(dn.valid), 128'd0);
    chk("rst_out_pc", 128'(dn.pc), 128'h3000);
    chk("rst_out_a3", 128'(dn.a3), 128'd0);
    chk("rst_out_data", 128'(dn.data), 128'd0);
    chk("rst_in_ready", 128'(up.ready), 128'd1);
    reset = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 96'd0);
    tick();
    chk("idle_out_valid", 128'(dn.valid), 128'd0);

    // 2: streaming, then 5: drain bubble
    dn.ready = 1'b1;
    drive(1'b1, 32'h0000_3000, 5'd1, D0);
    expect_beat(32'h0000_3000, 5'd1, D0);
    tick();
    chk("lat1_out_valid", 128'(dn.valid), 128'd1);
    chk("lat1_out_pc", 128'(dn.pc), 128'h3000);
    chk("stream_in_ready0", 128'(up.ready), 128'd1);
    drive(1'b1, 32'h0000_3004, 5'd2, D1);
    expect_beat(32'h0000_3004, 5'd2, D1);
    tick();
    chk("stream_in_ready1", 128'(up.ready), 128'd1);
    drive(1'b1, 32'h0000_3008, 5'd8, D2);
    expect_beat(32'h0000_3008, 5'd8, D2);
    tick();
    chk("stream_in_ready2", 128'(up.ready), 128'd1);
    chk("stream_out_pc2", 128'(dn.pc), 128'h3008);
    drive(1'b0, 32'h0, 5'd0, 96'd0);
    tick();
    chk("bubble_out_valid", 128'(dn.valid), 128'd0);
    chk("bubble_out_a3", 128'(dn.a3), 128'd0);
    chk("bubble_out_data", 128'(dn.data), 128'(D2));
    chk("bubble_out_pc", 128'(dn.pc), 128'h3008);
    chk("stream_q_empty", 128'(exp_q.size()), 128'd0);

    // 3: backpressure fills the skid entry
    dn.ready = 1'b0;
    drive(1'b1, 32'h0000_3000, 5'd3, D1);
    expect_beat(32'h0000_3000, 5'd3, D1);
    tick();
    drive(1'b1, 32'h0000_3004, 5'd4, D2);
    expect_beat(32'h0000_3004, 5'd4, D2);
    tick();
    chk("bp_in_ready", 128'(up.ready), 128'd0);
    chk("bp_out_pc", 128'(dn.pc), 128'h3000);
    drive(1'b1, 32'h0000_3008, 5'd5, D0);
    tick();
    tick();
    chk("bp_hold_in_ready", 128'(up.ready), 128'd0);
    chk("bp_hold_out_pc", 128'(dn.pc), 128'h3000);
    chk("bp_hold_out_a3", 128'(dn.a3), 128'd3);
    dn.ready = 1'b1;
    tick();
    chk("bp_rel_out_pc", 128'(dn.pc), 128'h3004);
    chk("bp_rel_in_ready", 128'(up.ready), 128'd1);
    expect_beat(32'h0000_3008, 5'd5, D0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 96'd0);
    tick();
    chk("bp_q_empty", 128'(exp_q.size()), 128'd0);
    chk("bp_drain_valid", 128'(dn.valid), 128'd0);

    // 4: flush in FULL with a concurrent input beat
    dn.ready = 1'b0;
    drive(1'b1, 32'h0000_3020, 5'd9, D0);
    tick();
    drive(1'b1, 32'h0000_3024, 5'd10, D1);
    tick();
    chk("fl_full_in_ready", 128'(up.ready), 128'd0);
    drive(1'b1, 32'h0000_300C, 5'd11, D2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 96'd0);
    chk("fl_out_valid", 128'(dn.valid), 128'd0);
    chk("fl_out_a3", 128'(dn.a3), 128'd0);
    chk("fl_out_pc", 128'(dn.pc), 128'h3000);
    chk("fl_out_data", 128'(dn.data), 128'd0);
    chk("fl_in_ready", 128'(up.ready), 128'd1);
    dn.ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("fl_stays_empty", 128'(dn.valid), 128'd0);

    // flush in ONE while a beat would be accepted
    drive(1'b1, 32'h0000_3030, 5'd12, D0);
    dn.ready = 1'b0;
    tick();
    drive(1'b1, 32'h0000_3034, 5'd13, D1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 96'd0);
    chk("fl1_out_valid", 128'(dn.valid), 128'd0);
    chk("fl1_out_pc", 128'(dn.pc), 128'h3000);
    dn.ready = 1'b1;
    tick();
    tick();
    chk("fl1_stays_empty", 128'(dn.valid), 128'd0);

`ifdef PIPE_STAGE_PERF_EN
    // 6: counters, 3 stall cycles and 4 empty cycles after reset
    reset = 1'b1;
    dn.ready = 1'b0;
    tick();
    chk("perf_rst_stall", 128'(stall_cnt), 128'd0);
    chk("perf_rst_bubble", 128'(bubble_cnt), 128'd0);
    reset = 1'b0;
    drive(1'b1, 32'h0000_3040, 5'd14, D2);
    expect_beat(32'h0000_3040, 5'd14, D2);
    tick();
    drive(1'b0, 32'h0, 5'd0, 96'd0);
    for (int i = 0; i < 3; i++) tick();
    dn.ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("perf_stall", 128'(stall_cnt), 128'd3);
    chk("perf_bubble", 128'(bubble_cnt), 128'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    // flush cycle itself is empty, so bubble advances by one, not to zero
    chk("perf_fl_stall", 128'(stall_cnt), 128'd3);
    chk("perf_fl_bubble", 128'(bubble_cnt), 128'd5);
`endif

    chk("final_q_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
